// File: rtl/codificador_programa_if.sv
// codificador_programa_if: symbolic-op handshake and instruction-memory write port
// of the program encoder; master drives ops, slave is the encoder.
interface codificador_programa_if #(
   parameter int ADDR_W = 5
);
   logic              start;
   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [11:0]       imm;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   count;
   logic              err;

   modport master (
      output start, op_valid, op, rd, rs1, rs2, imm,
      input  op_ready, mem_we, mem_addr, mem_wdata, busy, done, count, err
   );

   modport slave (
      input  start, op_valid, op, rd, rs1, rs2, imm,
      output op_ready, mem_we, mem_addr, mem_wdata, busy, done, count, err
   );
endinterface

// File: rtl/codificador_programa.sv
// codificador_programa: encodes symbolic RV32I ops and writes them to instruction memory from word 0.
// Define CODIFICADOR_TERM_EN to append a zero terminator word and reserve the last slot for it.
module codificador_programa #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input logic                  clk,
   input logic                  reset,
   codificador_programa_if.slave bus
);
`ifdef CODIFICADOR_TERM_EN
   localparam bit TERM_EN = 1'b1;
   typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, TERM, DONE} state_t;
`else
   localparam bit TERM_EN = 1'b0;
   typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
`endif
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH - int'(TERM_EN));

   state_t            r_state, w_next;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [ADDR_W:0]   r_count;
   logic              r_err;
   logic [31:0]       w_word;
   logic              w_fire, w_end, w_room, w_wr, w_start;

   assign w_fire  = bus.op_valid && bus.op_ready;
   assign w_end   = bus.op == 3'd7;
   assign w_room  = r_count < LIMIT;
   assign w_wr    = w_fire && (w_end ? TERM_EN : w_room);
   assign w_start = bus.start && (r_state == IDLE || r_state == DONE);

   always_comb begin
      w_word = '0;
      case (bus.op)
         3'd0:    w_word = {bus.imm, bus.rs1, 3'b010, bus.rd, 7'b0000011};
         3'd1:    w_word = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
         3'd2:    w_word = {7'b0100000, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
         3'd3:    w_word = {7'b0000000, bus.rs2, bus.rs1, 3'b100, bus.rd, 7'b0110011};
         3'd4:    w_word = {bus.imm, bus.rs1, 3'b000, bus.rd, 7'b0010011};
         3'd5:    w_word = {7'b0000000, bus.rs2, bus.rs1, 3'b101, bus.rd, 7'b0110011};
         3'd6:    w_word = {bus.imm[11], bus.imm[9:4], bus.rs2, bus.rs1, 3'b000, bus.imm[3:0], bus.imm[10], 7'b1100011};
         default: w_word = '0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: w_next = bus.start ? ACCEPT : r_state;
`ifdef CODIFICADOR_TERM_EN
         ACCEPT:     if (w_fire) w_next = w_wr ? (w_end ? TERM : WRITE) : DONE;
         TERM:       w_next = DONE;
`else
         ACCEPT:     if (w_fire) w_next = w_wr ? WRITE : DONE;
`endif
         WRITE:      w_next = ACCEPT;
         default:    w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;

   // r_we is high exactly in WRITE/TERM, so it doubles as the count advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_we <= w_wr;
         if (w_wr) begin
            r_addr  <= r_count[ADDR_W-1:0];
            r_wdata <= w_end ? '0 : w_word;
         end
         if (w_start) begin
            r_count <= '0;
            r_err   <= 1'b0;
         end else if (r_we) r_count <= r_count + 1'b1;
         if (w_fire && !w_end && !w_room) r_err <= 1'b1;
      end
   end

   assign bus.op_ready  = r_state == ACCEPT;
   assign bus.busy      = !(r_state == IDLE || r_state == DONE);
   assign bus.done      = r_state == DONE;
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.count     = r_count;
   assign bus.err       = r_err;
endmodule
